result_display_mux: RTL and testbench
=====================================

// Module: result_display_mux
// PURPOSE
//  Downstream display stage for the I2C server/client core. Filters the core's
//  16-bit result word (or its 8-bit device id) until it is stable, latches it,
//  and time-multiplexes it as 4 hex digits on a common-anode 7-segment display.
//  Changes that do not hold long enough never reach the display.
// PARAMETERS
//  REFRESH_DIV    50000  clk cycles each digit is driven; must be >= 2
//  STABLE_CYCLES  16     consecutive equal samples needed to update the display; must be >= 2
//  BLANK_LZ       1      1: blank leading-zero digits 3..1; 0: always show all 4 digits
// PORTS
//  clk      in   1   system clock, rising edge
//  reset    in   1   synchronous, active-high
//  data_in  in   16  result word from the server/client core
//  id_in    in   8   device id from the server/client core
//  show_id  in   1   1: display {8'h00,id_in}; 0: display data_in
//  an       out  4   digit enables, active-low; an[0] = rightmost digit = disp[3:0]
//  seg      out  7   {g,f,e,d,c,b,a}, active-low
//  dp       out  1   decimal point, active-low
//  upd      out  1   one-cycle pulse when the displayed value changes
// BEHAVIOUR
//  Clock and reset:
//  - One clock. Reset is synchronous and active-high.
//  - All outputs are registered.
//  - Reset values: an=4'hF, seg=7'h7F, dp=1, upd=0.
//  - Reset also clears cand=0, cnt=0, disp=0, disp_id=0, div=0, idx=0.
//  - Reset asserted mid-operation takes effect at the next edge. No partial scan or update survives it.
//  Sample and stability filter:
//  - sample = {show_id, show_id ? {8'h00,id_in} : data_in} (17 bits).
//  - If sample != cand: cand <= sample, cnt <= 1.
//  - Otherwise: if cnt == STABLE_CYCLES-1 and cand != {disp_id,disp}, load {disp_id,disp} <= cand and pulse upd=1 for one cycle.
//  - cnt increments each such edge and saturates at STABLE_CYCLES.
//  - Result: a value presented on STABLE_CYCLES consecutive edges loads on the last of them. upd is high in the following cycle.
//  - A value equal to the current display never pulses upd.
//  - A change in show_id alone also passes through the filter.
//  Scanning:
//  - div counts 0..REFRESH_DIV-1. On its wrap, idx advances 0->1->2->3->0.
//  - Each edge registers an = ~(1<<idx) and seg = hexdecode(disp[4*idx+3:4*idx]).
//  - Decode table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
//  - Blanking: if BLANK_LZ=1, idx>0, and disp nibbles idx..3 are all zero, then an=4'hF and seg=7'h7F for that slot.
//  - Digit 0 is never blanked. Internal zeros are never blanked.
//  - dp = 0 only when idx==0 and disp_id==1; otherwise dp = 1.
//  - A disp update mid-scan is used from the next edge. The scan position is not reset by an update.
// TESTING (bench uses REFRESH_DIV=4, STABLE_CYCLES=16)
//  1. Hold reset 10 cycles, data_in=0 -> an=F, seg=7F, dp=1, upd=0 during reset; after release, digit 0 shows seg=40 and digits 1..3 are blanked.
//  2. data_in=16'h1A2F held from edge E1 -> upd=1 only in the cycle after E16; scan then shows an=E/D/B/7 with seg=0E/24/08/79.
//  3. Hold 16'h1A2F, then 16'h1234 for 10 cycles, then 16'h1A2F -> upd stays 0 and the display is unchanged.
//  4. show_id=1, id_in=8'h5C held 16 cycles -> upd pulses once; digit 0 shows seg=46 with dp=0; digit 1 shows seg=12; digits 2,3 blanked.
//  5. data_in=16'h0100, BLANK_LZ=1 -> digits 0,1 show 40 and digit 2 shows 79; only digit 3 is blanked.
//  6. Assert reset for 1 cycle while idx=2, cnt=10 -> next edge gives reset output values; the first scan slot after release is idx=0.

Source files
------------

// File: rtl/result_display_mux.sv
// Stability-filtered result/ID latch driving a 4-digit common-anode 7-segment
// display by time multiplexing; unstable input glitches never reach the display.
module result_display_mux #(
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 16,
  parameter bit BLANK_LZ      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [7:0]  id_in,
  input  logic        show_id,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        upd
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [16:0]      sample;
  logic [16:0]      cand;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      disp;
  logic             disp_id;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  logic [3:0]       nibble;
  logic             blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  function automatic logic [6:0] hexdecode(input logic [3:0] n);
    case (n)
      4'h0: hexdecode = 7'h40;
      4'h1: hexdecode = 7'h79;
      4'h2: hexdecode = 7'h24;
      4'h3: hexdecode = 7'h30;
      4'h4: hexdecode = 7'h19;
      4'h5: hexdecode = 7'h12;
      4'h6: hexdecode = 7'h02;
      4'h7: hexdecode = 7'h78;
      4'h8: hexdecode = 7'h00;
      4'h9: hexdecode = 7'h10;
      4'hA: hexdecode = 7'h08;
      4'hB: hexdecode = 7'h03;
      4'hC: hexdecode = 7'h46;
      4'hD: hexdecode = 7'h21;
      4'hE: hexdecode = 7'h06;
      default: hexdecode = 7'h0E;
    endcase
  endfunction

  // The show_id bit rides along in the sample so a mode switch alone is filtered too.
  assign sample = {show_id, show_id ? {8'h00, id_in} : data_in};
  assign nibble = disp[4*idx +: 4];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (disp[15:4]  == 12'h000);
      2'd2:    blank = (disp[15:8]  == 8'h00);
      2'd3:    blank = (disp[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    if (!BLANK_LZ) blank = 1'b0;

    an_next  = blank ? 4'hF  : ~(4'b0001 << idx);
    seg_next = blank ? 7'h7F : hexdecode(nibble);
    dp_next  = ~((idx == 2'd0) && disp_id);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand    <= '0;
      cnt     <= '0;
      disp    <= '0;
      disp_id <= 1'b0;
      div     <= '0;
      idx     <= '0;
      an      <= 4'hF;
      seg     <= 7'h7F;
      dp      <= 1'b1;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (sample != cand) begin
        cand <= sample;
        cnt  <= CNT_W'(1);
      end else begin
        if ((cnt == CNT_W'(STABLE_CYCLES - 1)) && (cand != {disp_id, disp})) begin
          {disp_id, disp} <= cand;
          upd             <= 1'b1;
        end
        if (cnt != CNT_W'(STABLE_CYCLES)) cnt <= cnt + CNT_W'(1);
      end

      if (div == DIV_W'(REFRESH_DIV - 1)) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end

      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_result_display_mux.sv
// Scoreboard bench for result_display_mux: expected upd cycles are queued at
// stimulus time and retired by a monitor; each display is checked over one scan period.
module tb_result_display_mux;

  localparam int REFRESH_DIV   = 4;
  localparam int STABLE_CYCLES = 16;
  localparam int SCAN_PERIOD   = 4 * REFRESH_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic [7:0]  id_in = 8'h00;
  logic        show_id = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  result_display_mux #(
    .REFRESH_DIV(REFRESH_DIV),
    .STABLE_CYCLES(STABLE_CYCLES),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .id_in(id_in),
    .show_id(show_id),
    .an(an),
    .seg(seg),
    .dp(dp),
    .upd(upd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every upd pulse must match the oldest queued expectation; -1 flags an unexpected pulse.
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check("upd_cycle", cyc, e);
    end
  end

  // Observe one full scan period; e* = expected segments per digit, 7F meaning blanked.
  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input logic dp0);
    logic [6:0] e [4];
    int cnt [6];
    int d;
    int nblank;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    for (int i = 0; i < SCAN_PERIOD; i++) begin
      @(negedge clk);
      case (an)
        4'hE:    d = 0;
        4'hD:    d = 1;
        4'hB:    d = 2;
        4'h7:    d = 3;
        4'hF:    d = 4;
        default: d = 5;
      endcase
      cnt[d]++;
      if (d < 4) begin
        check({tag, "_seg"}, seg, e[d]);
        check({tag, "_dp"}, dp, (d == 0) ? dp0 : 1'b1);
      end else if (d == 4) begin
        check({tag, "_blank_seg"}, seg, 7'h7F);
        check({tag, "_blank_dp"}, dp, 1'b1);
      end
    end
    nblank = 0;
    for (int i = 0; i < 4; i++) begin
      if (e[i] == 7'h7F) nblank++;
      check({tag, "_slots"}, cnt[i], (e[i] == 7'h7F) ? 0 : REFRESH_DIV);
    end
    check({tag, "_blank_slots"}, cnt[4], nblank * REFRESH_DIV);
    check({tag, "_bad_an"}, cnt[5], 0);
  endtask

  // Drive a new sample at a negedge; its update shows as upd after the 16th edge.
  task automatic expect_update();
    exp_q.push_back(cyc + STABLE_CYCLES);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // 1: reset state, then the all-zero display.
    repeat (10) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_upd", upd, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_an", an, 4'hE);
    check("rel_seg", seg, 7'h40);
    scan_check("t1", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b1);

    // 2: stable value loads after 16 edges.
    data_in = 16'h1A2F;
    expect_update();
    repeat (20) @(negedge clk);
    scan_check("t2", 7'h0E, 7'h24, 7'h08, 7'h79, 1'b1);

    // 3: short glitch, then the displayed value again: no update.
    data_in = 16'h1234;
    repeat (10) @(negedge clk);
    data_in = 16'h1A2F;
    repeat (20) @(negedge clk);
    scan_check("t3", 7'h0E, 7'h24, 7'h08, 7'h79, 1'b1);

    // 4: device id with decimal point.
    show_id = 1'b1;
    id_in   = 8'h5C;
    expect_update();
    repeat (20) @(negedge clk);
    scan_check("t4", 7'h46, 7'h12, 7'h7F, 7'h7F, 1'b0);

    // 4b: same digits, only show_id changes.
    data_in = 16'h005C;
    repeat (20) @(negedge clk);
    show_id = 1'b0;
    expect_update();
    repeat (20) @(negedge clk);
    scan_check("t4b", 7'h46, 7'h12, 7'h7F, 7'h7F, 1'b1);

    // 5: internal zero is shown, only the leading digit is blanked.
    data_in = 16'h0100;
    expect_update();
    repeat (20) @(negedge clk);
    scan_check("t5", 7'h40, 7'h40, 7'h79, 7'h7F, 1'b1);

    // 6: align to the first digit-1 slot, then reset with idx=2 and cnt=10.
    n = 0;
    while (an == 4'hD && n < 64) begin @(negedge clk); n++; end
    while (an != 4'hD && n < 64) begin @(negedge clk); n++; end
    check("t6_align_timeout", (n < 64), 1'b1);
    repeat (9) @(negedge clk);
    data_in = 16'h7777;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_an", an, 4'hF);
    check("t6_rst_seg", seg, 7'h7F);
    check("t6_rst_dp", dp, 1'b1);
    check("t6_rst_upd", upd, 1'b0);
    reset = 1'b0;
    expect_update();
    @(negedge clk);
    check("t6_first_an", an, 4'hE);
    check("t6_first_seg", seg, 7'h40);
    repeat (20) @(negedge clk);
    scan_check("t6", 7'h78, 7'h78, 7'h78, 7'h78, 1'b1);

    repeat (4) @(negedge clk);
    check("upd_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
